// File: rtl/branch_pc_controller.sv
//==============================================================================
// Module      : branch_pc_controller
// Description : Round-robin per-thread PC sequencer with prioritised branch
//               selection. Optional macro BRANCH_PC_CONTROLLER_MULTIJUMP_ERR_EN
//               adds a sticky multi_jump error flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module branch_pc_controller #(
  parameter int PC_WIDTH           = 10,
  parameter int BRANCH_COUNT       = 4,
  parameter int THREAD_COUNT       = 8,
  parameter int THREAD_COUNT_WIDTH = 3,
  parameter int INITIAL_THREAD     = 0,
  parameter int START_PC           = 0,
  localparam int c_IDX_WIDTH       = (BRANCH_COUNT > 1) ? $clog2(BRANCH_COUNT) : 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [BRANCH_COUNT*PC_WIDTH-1:0] destination,
  input  logic [BRANCH_COUNT-1:0]        jump,
  input  logic [BRANCH_COUNT-1:0]        cancel,
  input  logic                           hold,
  output logic [PC_WIDTH-1:0]            pc_out,
  output logic [THREAD_COUNT_WIDTH-1:0]  thread_out,
  output logic                           taken_out,
  output logic                           cancel_out,
  output logic [c_IDX_WIDTH-1:0]         branch_index
`ifdef BRANCH_PC_CONTROLLER_MULTIJUMP_ERR_EN
  ,
  output logic                           multi_jump
`endif
);

  localparam logic [THREAD_COUNT_WIDTH-1:0] c_LAST_THREAD = THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);
  localparam logic [THREAD_COUNT_WIDTH-1:0] c_INIT_THREAD = THREAD_COUNT_WIDTH'(INITIAL_THREAD);
  localparam logic [PC_WIDTH-1:0]           c_START_PC    = PC_WIDTH'(START_PC);

  logic [THREAD_COUNT_WIDTH-1:0] r_thread;
  logic [PC_WIDTH-1:0]           r_pc [THREAD_COUNT];

  logic [PC_WIDTH-1:0]           r_pc_out;
  logic [THREAD_COUNT_WIDTH-1:0] r_thread_out;
  logic                          r_taken;
  logic                          r_cancel;
  logic [c_IDX_WIDTH-1:0]        r_branch_index;

  logic [THREAD_COUNT_WIDTH-1:0] w_thread_next;
  logic [PC_WIDTH-1:0]           w_stored_pc;
  logic [PC_WIDTH-1:0]           w_next_pc;
  logic                          w_found;
  logic [c_IDX_WIDTH-1:0]        w_winner;
  logic                          w_taken;
  logic                          w_cancel;
  logic [c_IDX_WIDTH-1:0]        w_branch_index;

  assign w_thread_next = (r_thread == c_LAST_THREAD) ? '0 : r_thread + 1'b1;
  assign w_stored_pc   = r_pc[r_thread];

  // Scan from the top so the lowest jumping index is the last one written.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = BRANCH_COUNT - 1; i >= 0; i--) begin
      if (jump[i]) begin
        w_found  = 1'b1;
        w_winner = c_IDX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    w_next_pc      = w_stored_pc + 1'b1;
    w_taken        = 1'b0;
    w_cancel       = 1'b0;
    w_branch_index = '0;
    if (hold) begin
      w_next_pc = w_stored_pc;
    end else if (w_found) begin
      w_next_pc      = destination[w_winner*PC_WIDTH +: PC_WIDTH];
      w_taken        = 1'b1;
      w_cancel       = cancel[w_winner];
      w_branch_index = w_winner;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_thread       <= c_INIT_THREAD;
      for (int t = 0; t < THREAD_COUNT; t++) begin
        r_pc[t] <= c_START_PC;
      end
      r_pc_out       <= c_START_PC;
      r_thread_out   <= '0;
      r_taken        <= 1'b0;
      r_cancel       <= 1'b0;
      r_branch_index <= '0;
    end else begin
      r_thread       <= w_thread_next;
      r_pc[r_thread] <= w_next_pc;
      r_pc_out       <= w_next_pc;
      r_thread_out   <= r_thread;
      r_taken        <= w_taken;
      r_cancel       <= w_cancel;
      r_branch_index <= w_branch_index;
    end
  end

  assign pc_out       = r_pc_out;
  assign thread_out   = r_thread_out;
  assign taken_out    = r_taken;
  assign cancel_out   = r_cancel;
  assign branch_index = r_branch_index;

`ifdef BRANCH_PC_CONTROLLER_MULTIJUMP_ERR_EN
  localparam logic [BRANCH_COUNT-1:0] c_ONE = BRANCH_COUNT'(1);

  logic r_multi_jump;
  logic w_many_jumps;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_many_jumps = |(jump & (jump - c_ONE));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_multi_jump <= 1'b0;
    end else if (!hold && w_many_jumps) begin
      r_multi_jump <= 1'b1;
    end
  end

  assign multi_jump = r_multi_jump;
`endif

endmodule

`default_nettype wire
